// File: rtl/pipe_stage_reg.sv
// Elastic two-entry (main + skid) pipeline stage register with valid/ready handshake and flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_DATA   = 2,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_WIDTH-1:0]          in_pc,
    input  logic [31:0]                    in_inst,
    input  logic [NUM_DATA*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_WIDTH-1:0]          out_pc,
    output logic [31:0]                    out_inst,
    output logic [NUM_DATA*DATA_WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                    perf_stall_cnt,
    output logic [31:0]                    perf_bubble_cnt
`endif
);

    localparam int DW = NUM_DATA * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t                  state_r, state_nxt;
    logic                    ready_r;
    logic                    valid_r;
    logic [31:0]             out_inst_r;
    logic [ADDR_WIDTH-1:0]   main_pc_r, main_pc_nxt;
    logic [31:0]             main_inst_r, main_inst_nxt;
    logic [DW-1:0]           main_data_r, main_data_nxt;
    logic [ADDR_WIDTH-1:0]   skid_pc_r, skid_pc_nxt;
    logic [31:0]             skid_inst_r, skid_inst_nxt;
    logic [DW-1:0]           skid_data_r, skid_data_nxt;
    logic                    accept_s;
    logic                    emit_s;

    // ready_r only reflects skid occupancy; flush gates it without a path from out_ready
    assign in_ready  = ready_r & ~flush;
    assign out_valid = valid_r;
    assign out_inst  = out_inst_r;
    assign out_pc    = main_pc_r;
    assign out_data  = main_data_r;
    assign accept_s  = in_valid & in_ready;
    assign emit_s    = valid_r & out_ready;

    // Occupancy transitions and payload steering between input, main and skid
    always_comb begin
        state_nxt     = state_r;
        main_pc_nxt   = main_pc_r;
        main_inst_nxt = main_inst_r;
        main_data_nxt = main_data_r;
        skid_pc_nxt   = skid_pc_r;
        skid_inst_nxt = skid_inst_r;
        skid_data_nxt = skid_data_r;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt     = ST_FULL;
                        main_pc_nxt   = in_pc;
                        main_inst_nxt = in_inst;
                        main_data_nxt = in_data;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s && emit_s) begin
                        state_nxt     = ST_FULL;
                        main_pc_nxt   = in_pc;
                        main_inst_nxt = in_inst;
                        main_data_nxt = in_data;
                    end else if (accept_s) begin
                        state_nxt     = ST_SKID;
                        skid_pc_nxt   = in_pc;
                        skid_inst_nxt = in_inst;
                        skid_data_nxt = in_data;
                    end else if (emit_s) begin
                        state_nxt = ST_EMPTY;
                    end else begin
                        state_nxt = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (emit_s) begin
                        state_nxt     = ST_FULL;
                        main_pc_nxt   = skid_pc_r;
                        main_inst_nxt = skid_inst_r;
                        main_data_nxt = skid_data_r;
                    end else begin
                        state_nxt = ST_SKID;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State, payload and registered output flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            ready_r     <= 1'b0;
            valid_r     <= 1'b0;
            out_inst_r  <= NOP_INST;
            main_pc_r   <= '0;
            main_inst_r <= NOP_INST;
            main_data_r <= '0;
            skid_pc_r   <= '0;
            skid_inst_r <= NOP_INST;
            skid_data_r <= '0;
        end else begin
            state_r     <= state_nxt;
            ready_r     <= (state_nxt != ST_SKID);
            valid_r     <= (state_nxt != ST_EMPTY);
            out_inst_r  <= (state_nxt != ST_EMPTY) ? main_inst_nxt : NOP_INST;
            main_pc_r   <= main_pc_nxt;
            main_inst_r <= main_inst_nxt;
            main_data_r <= main_data_nxt;
            skid_pc_r   <= skid_pc_nxt;
            skid_inst_r <= skid_inst_nxt;
            skid_data_r <= skid_data_nxt;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : (v + 32'd1);
    endfunction

    // Saturating stall and bubble counters; flush deliberately has no effect here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt  <= 32'd0;
            perf_bubble_cnt <= 32'd0;
        end else begin
            perf_stall_cnt  <= (valid_r && !out_ready) ? sat_inc(perf_stall_cnt) : perf_stall_cnt;
            perf_bubble_cnt <= (!valid_r) ? sat_inc(perf_bubble_cnt) : perf_bubble_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a two-deep FIFO reference model.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [95:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    pipe_stage_reg #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_DATA   (3),
        .NOP_INST   (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [95:0] data;
    } ent_t;

    ent_t        q[$];
    ent_t        last_head;
    logic        started;
    logic [31:0] m_stall;
    logic [31:0] m_bubble;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return started && (q.size() < 2) && !flush;
    endfunction

    task automatic model_reset();
        q.delete();
        last_head.pc   = 32'd0;
        last_head.inst = NOP;
        last_head.data = 96'd0;
        started        = 1'b0;
        m_stall        = 32'd0;
        m_bubble       = 32'd0;
    endtask

    // One clock edge of the reference model: a FIFO of depth two
    task automatic model_edge();
        logic acc;
        logic emit;
        ent_t e;
        acc  = in_valid && exp_ready();
        emit = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && (m_stall != 32'hFFFFFFFF)) m_stall++;
        if ((q.size() == 0) && (m_bubble != 32'hFFFFFFFF)) m_bubble++;
        started = 1'b1;
        if (flush) begin
            q.delete();
        end else begin
            if (emit) void'(q.pop_front());
            if (acc) begin
                e.pc = in_pc; e.inst = in_inst; e.data = in_data;
                q.push_back(e);
            end
        end
        if (q.size() > 0) last_head = q[0];
    endtask

    task automatic check_outputs();
        ent_t e;
        logic [31:0] e_inst;
        e = (q.size() > 0) ? q[0] : last_head;
        e_inst = (q.size() > 0) ? e.inst : NOP;
        check_eq("out_valid", 128'(out_valid), 128'(q.size() > 0));
        check_eq("out_inst", 128'(out_inst), 128'(e_inst));
        check_eq("out_pc", 128'(out_pc), 128'(e.pc));
        check_eq("out_data", 128'(out_data), 128'(e.data));
`ifdef PIPE_STAGE_PERF_EN
        check_eq("perf_stall", 128'(perf_stall_cnt), 128'(m_stall));
        check_eq("perf_bubble", 128'(perf_bubble_cnt), 128'(m_bubble));
`endif
    endtask

    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [95:0] data, input logic ordy, input logic fl);
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        in_data   = data;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_eq("in_ready", 128'(in_ready), 128'(exp_ready()));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'd0; in_inst = 32'd0; in_data = 96'd0;
        #12;
        do_reset();
        step(1'b0, 32'd0, 32'd0, 96'd0, 1'b1, 1'b0);

        // streaming at full rate
        step(1'b1, 32'h0, 32'h00A00093, 96'h1, 1'b1, 1'b0);
        step(1'b1, 32'h4, 32'h00B00113, 96'h2, 1'b1, 1'b0);
        step(1'b1, 32'h8, 32'h00C00193, 96'h3, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 96'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 96'h0, 1'b1, 1'b0);

        // backpressure with retry of the refused entry
        step(1'b1, 32'h10, 32'h11, 96'h10, 1'b0, 1'b0);
        step(1'b1, 32'h14, 32'h15, 96'h14, 1'b0, 1'b0);
        step(1'b1, 32'h18, 32'h19, 96'h18, 1'b0, 1'b0);
        check_eq("bp_head", 128'(out_pc), 128'h10);
        step(1'b1, 32'h18, 32'h19, 96'h18, 1'b1, 1'b0);
        check_eq("bp_second", 128'(out_pc), 128'h14);
        step(1'b1, 32'h18, 32'h19, 96'h18, 1'b1, 1'b0);
        check_eq("bp_third", 128'(out_pc), 128'h18);
        step(1'b0, 32'h0, 32'h0, 96'h0, 1'b1, 1'b0);

        // flush while holding two entries, with an input offered
        step(1'b1, 32'h30, 32'h31, 96'h30, 1'b0, 1'b0);
        step(1'b1, 32'h34, 32'h35, 96'h34, 1'b0, 1'b0);
        step(1'b1, 32'h20, 32'h21, 96'h20, 1'b0, 1'b1);
        check_eq("flush_inst", 128'(out_inst), 128'(NOP));
        step(1'b0, 32'h0, 32'h0, 96'h0, 1'b1, 1'b0);

        // wide payload pass-through
        step(1'b1, 32'hFFFFFFF0, 32'h00A00093, {32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF}, 1'b1, 1'b0);
        check_eq("ch0", 128'(out_data[31:0]), 128'hDEADBEEF);
        check_eq("ch1", 128'(out_data[63:32]), 128'h12345678);
        check_eq("ch2", 128'(out_data[95:64]), 128'hCAFEF00D);
        check_eq("wide_pc", 128'(out_pc), 128'hFFFFFFF0);

        // async reset while both entries are occupied
        step(1'b1, 32'h40, 32'h41, 96'h40, 1'b0, 1'b0);
        step(1'b1, 32'h44, 32'h45, 96'h44, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();
        step(1'b1, 32'h50, 32'h51, 96'h50, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 96'h0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom, {$urandom, $urandom, $urandom},
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
